// File: rtl/led_req_arb.sv
// Shares one board LED between several requesters: queue, priority grant, timed display, dark gap.
// Optional preemption by a higher-priority requester is enabled with `define LED_ARB_PREEMPT_EN.
module led_req_arb #(
    parameter int WD_REQ_NUMB  = 4,
    parameter int WD_REQ_IDX   = 2,
    parameter int WD_TICK_CNT  = 24,
    parameter int NB_HOLD_TICK = 8'h10,
    parameter int WD_ERR_INFO  = 4
) (
    input  logic                     i_sys_clk,
    input  logic                     i_sys_reset,
    input  logic [WD_REQ_NUMB-1:0]   i_bus_req_pulse,
    input  logic [2*WD_REQ_NUMB-1:0] i_bus_req_mode,
    output logic                     o_port_led_driv,
    output logic [WD_REQ_IDX-1:0]    o_bus_grant_idx,
    output logic                     o_bus_busy,
    output logic [WD_ERR_INFO-1:0]   m_err_led_info1
);

    localparam int HOLD_TICKS = (NB_HOLD_TICK < 1) ? 1 : NB_HOLD_TICK;
    localparam int WD_HOLD    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [WD_HOLD-1:0] HOLD_LAST = WD_HOLD'(HOLD_TICKS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [WD_TICK_CNT-1:0] tick_cnt_reg, tick_cnt_next;
    logic                   tick;
    logic [WD_REQ_NUMB-1:0] pend_reg, pend_next;
    logic [1:0]             state_reg, state_next;
    logic [WD_REQ_IDX-1:0]  grant_reg, grant_next;
    logic [1:0]             mode_reg, mode_next;
    logic [WD_HOLD-1:0]     hold_reg, hold_next;
    logic                   led_reg, led_next;
    logic [2:0]             err_reg, err_next;

    logic [WD_REQ_NUMB-1:0] has_lower;
    logic [WD_REQ_NUMB-1:0] first_hot;
    logic [WD_REQ_NUMB-1:0] clr_mask;
    logic [WD_REQ_IDX-1:0]  win_idx;
    logic [1:0]             win_mode;
    logic                   any_pend;
    logic                   do_grant;

    assign tick_cnt_next = tick_cnt_reg + 1'b1;
    assign tick          = &tick_cnt_reg;
    assign any_pend      = |pend_reg;

    // Lowest pending index wins: a bit is the winner when no lower bit is pending.
    genvar gi;
    generate
        for (gi = 0; gi < WD_REQ_NUMB; gi = gi + 1) begin : g_prio
            if (gi == 0) begin : g_first
                assign has_lower[gi] = 1'b0;
            end else begin : g_rest
                assign has_lower[gi] = has_lower[gi-1] | pend_reg[gi-1];
            end
            assign first_hot[gi] = pend_reg[gi] & ~has_lower[gi];
        end
    endgenerate

    always_comb begin
        win_idx  = '0;
        win_mode = 2'b00;
        for (int i = 0; i < WD_REQ_NUMB; i++) begin
            if (first_hot[i]) begin
                win_idx  = win_idx | WD_REQ_IDX'(i);
                win_mode = win_mode | i_bus_req_mode[2*i +: 2];
            end
        end
    end

`ifdef LED_ARB_PREEMPT_EN
    logic [WD_REQ_NUMB-1:0] above_mask;
    logic                   preempt;

    generate
        for (gi = 0; gi < WD_REQ_NUMB; gi = gi + 1) begin : g_above
            assign above_mask[gi] = (WD_REQ_IDX'(gi) < grant_reg);
        end
    endgenerate

    assign preempt = |(pend_reg & above_mask);
`endif

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        mode_next  = mode_reg;
        hold_next  = hold_reg;
        clr_mask   = '0;
        do_grant   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (any_pend) begin
                    do_grant = 1'b1;
                end
            end
            ST_SHOW: begin
                if (tick) begin
                    if (hold_reg == HOLD_LAST) begin
                        state_next = ST_GAP;
                    end else begin
                        hold_next = hold_reg + 1'b1;
                    end
                end
`ifdef LED_ARB_PREEMPT_EN
                // Preemption overrides a coincident end of hold; the old grant is dropped.
                if (preempt) begin
                    do_grant = 1'b1;
                end
`endif
            end
            ST_GAP: begin
                if (tick) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (do_grant) begin
            state_next = ST_SHOW;
            grant_next = win_idx;
            mode_next  = win_mode;
            hold_next  = '0;
            clr_mask   = first_hot;
        end
    end

    // A strobe coinciding with its own clear re-queues the request, so it is not a merge.
    assign pend_next = (pend_reg & ~clr_mask) | i_bus_req_pulse;

    always_comb begin
        err_next    = err_reg;
        err_next[0] = err_reg[0] | (|(i_bus_req_pulse & pend_reg & ~clr_mask));
        err_next[1] = err_reg[1] | (do_grant & (win_mode == 2'b11));
`ifdef LED_ARB_PREEMPT_EN
        err_next[2] = err_reg[2] | (do_grant & (state_reg == ST_SHOW));
`else
        err_next[2] = 1'b0;
`endif
    end

    always_comb begin
        led_next = 1'b0;
        if (state_next == ST_SHOW) begin
            case (mode_next)
                2'd1:    led_next = do_grant ? 1'b1 : (tick ? ~led_reg : led_reg);
                2'd2:    led_next = tick_cnt_next[WD_TICK_CNT-2];
                default: led_next = 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_reset) begin
        if (i_sys_reset) begin
            tick_cnt_reg <= '0;
            pend_reg     <= '0;
            state_reg    <= ST_IDLE;
            grant_reg    <= '0;
            mode_reg     <= 2'b00;
            hold_reg     <= '0;
            led_reg      <= 1'b0;
            err_reg      <= 3'b000;
        end else begin
            tick_cnt_reg <= tick_cnt_next;
            pend_reg     <= pend_next;
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            mode_reg     <= mode_next;
            hold_reg     <= hold_next;
            led_reg      <= led_next;
            err_reg      <= err_next;
        end
    end

    assign o_port_led_driv = led_reg;
    assign o_bus_grant_idx = grant_reg;
    assign o_bus_busy      = (state_reg != ST_IDLE);

    generate
        for (gi = 0; gi < WD_ERR_INFO; gi = gi + 1) begin : g_err
            if (gi < 3) begin : g_used
                assign m_err_led_info1[gi] = err_reg[gi];
            end else begin : g_zero
                assign m_err_led_info1[gi] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_led_req_arb.sv
// Directed bench for led_req_arb with a 16-cycle tick and a 3-tick hold.
// Cycle k means 1 time unit after the k-th rising edge since reset release.
module tb_led_req_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pulse = 4'b0000;
    logic [7:0] mode = 8'h00;
    logic       led;
    logic [1:0] idx;
    logic       busy;
    logic [3:0] err;

    int cyc   = 0;
    int n_cmp = 0;
    int n_mis = 0;

    led_req_arb #(
        .WD_REQ_NUMB (4),
        .WD_REQ_IDX  (2),
        .WD_TICK_CNT (4),
        .NB_HOLD_TICK(3),
        .WD_ERR_INFO (4)
    ) dut (
        .i_sys_clk      (clk),
        .i_sys_reset    (rst),
        .i_bus_req_pulse(pulse),
        .i_bus_req_mode (mode),
        .o_port_led_driv(led),
        .o_bus_grant_idx(idx),
        .o_bus_busy     (busy),
        .m_err_led_info1(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, expv);
        end else begin
            $display("ok   %s @cyc %0d: %0h", tag, cyc, obs);
        end
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic strobe(input logic [3:0] m);
        pulse = m;
        tick_to(cyc + 1);
        pulse = 4'b0000;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led",  led,  1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_idx",  idx,  2'd0);
        chk("rst_err",  err,  4'h0);
        rst = 1'b0;
        cyc = 0;

        // req1 mode 0: grant two cycles after the strobe, three ticks of display
        tick_to(5);
        strobe(4'b0010);
        chk("t1_pend_busy", busy, 1'b0);
        tick_to(7);
        chk("t1_busy", busy, 1'b1);
        chk("t1_idx",  idx,  2'd1);
        chk("t1_led",  led,  1'b1);
        tick_to(47);
        chk("t1_led_last", led, 1'b1);
        tick_to(48);
        chk("t1_led_gap",  led,  1'b0);
        chk("t1_busy_gap", busy, 1'b1);
        tick_to(63);
        chk("t1_gap_end", busy, 1'b1);
        tick_to(64);
        chk("t1_idle", busy, 1'b0);

        // req0 and req2 together: req0 first, req2 one cycle after IDLE entry
        tick_to(70);
        strobe(4'b0101);
        tick_to(72);
        chk("t2_idx0", idx,  2'd0);
        chk("t2_busy", busy, 1'b1);
        tick_to(112);
        chk("t2_gap", led, 1'b0);
        tick_to(128);
        chk("t2_idle_entry", busy, 1'b0);
        tick_to(129);
        chk("t2_idx2",  idx,  2'd2);
        chk("t2_busy2", busy, 1'b1);
        chk("t2_led2",  led,  1'b1);
        tick_to(192);
        chk("t2_done", busy, 1'b0);

        // req3 flash mode; mode change after grant must be ignored
        tick_to(195);
        mode = 8'b0100_0000;
        strobe(4'b1000);
        tick_to(197);
        chk("t3_led_grant", led, 1'b1);
        mode = 8'h00;
        tick_to(207);
        chk("t3_led_pre",  led, 1'b1);
        tick_to(208);
        chk("t3_led_tog1", led, 1'b0);
        tick_to(223);
        chk("t3_led_hold", led, 1'b0);
        tick_to(224);
        chk("t3_led_tog2", led, 1'b1);
        tick_to(239);
        chk("t3_busy_last", busy, 1'b1);
        tick_to(240);
        chk("t3_led_gap", led, 1'b0);
        tick_to(256);
        chk("t3_idle", busy, 1'b0);

        // req0 busy; req1 (mode 3) strobed twice while pending
        tick_to(260);
        strobe(4'b0001);
        chk("t4_err_clean", err, 4'h0);
        tick_to(265);
        mode = 8'b0000_1100;
        strobe(4'b0010);
        tick_to(270);
        strobe(4'b0010);
        chk("t4_err0", err, 4'h1);
        tick_to(321);
        chk("t4_idx1", idx, 2'd1);
        chk("t4_led",  led, 1'b1);
        chk("t4_err1", err, 4'h3);
        mode = 8'h00;
        tick_to(336);
        chk("t4_stable", led, 1'b1);
        tick_to(368);
        chk("t4_gap", led, 1'b0);
        tick_to(400);
        chk("t4_single", busy, 1'b0);

        // reset in the middle of SHOW with another request pending
        tick_to(402);
        strobe(4'b0100);
        tick_to(405);
        chk("t5_show", busy, 1'b1);
        tick_to(408);
        strobe(4'b0010);
        tick_to(410);
        rst = 1'b1;
        #2;
        chk("t5_led_async",  led,  1'b0);
        chk("t5_busy_async", busy, 1'b0);
        chk("t5_err_async",  err,  4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        tick_to(4);
        chk("t5_no_grant", busy, 1'b0);

        // req2 in SHOW, then req0 strobed
        tick_to(5);
        strobe(4'b0100);
        tick_to(7);
        chk("t6_idx2", idx, 2'd2);
        tick_to(10);
        strobe(4'b0001);
        tick_to(12);
`ifdef LED_ARB_PREEMPT_EN
        chk("t6_pre_idx", idx,  2'd0);
        chk("t6_pre_err", err,  4'h4);
        chk("t6_pre_led", led,  1'b1);
        tick_to(48);
        chk("t6_pre_gap", led, 1'b0);
        tick_to(64);
        chk("t6_pre_idle", busy, 1'b0);
        tick_to(80);
        chk("t6_pre_dropped", busy, 1'b0);
`else
        chk("t6_np_idx", idx, 2'd2);
        chk("t6_np_err", err, 4'h0);
        tick_to(48);
        chk("t6_np_gap", led, 1'b0);
        tick_to(64);
        chk("t6_np_idle", busy, 1'b0);
        tick_to(65);
        chk("t6_np_idx0", idx,  2'd0);
        chk("t6_np_busy", busy, 1'b1);
        tick_to(128);
        chk("t6_np_done", busy, 1'b0);
`endif

        // req3 fast flash follows bit 2 of the tick counter
        tick_to(130);
        mode = 8'b1000_0000;
        strobe(4'b1000);
        tick_to(132);
        chk("t7_idx3",     idx, 2'd3);
        chk("t7_fast_on",  led, 1'b1);
        tick_to(136);
        chk("t7_fast_off", led, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
